// File: rtl/wallace_pkg.sv
// Shared widths and the row type passed between Wallace reduction levels.
package wallace_pkg;
   localparam int OP_W    = 16;
   localparam int PROD_W  = 32;
   localparam int LATENCY = 4;

   typedef logic [PROD_W-1:0] row_t;
endpackage

// File: rtl/wallace_csa.sv
// Row-wide 3:2 carry-save compressor; carry row is pre-shifted to its weight.
module wallace_csa
   import wallace_pkg::*;
(
   input  row_t i_x,
   input  row_t i_y,
   input  row_t i_z,
   output row_t o_sum,
   output row_t o_carry
);

   // Carry out of bit 31 is dropped; the final product always fits in 32 bits.
   assign o_sum   = i_x ^ i_y ^ i_z;
   assign o_carry = ((i_x & i_y) | (i_x & i_z) | (i_y & i_z)) << 1;

endmodule

// File: rtl/wallace_pipe.sv
// Four-stage pipelined 16x16 unsigned Wallace-tree multiplier.
// Stages: operand regs, 16->6 rows, 6->2 rows, carry-propagate add.
module wallace_pipe
   import wallace_pkg::*;
(
   input  logic [OP_W-1:0]   a,
   input  logic [OP_W-1:0]   b,
   output logic [PROD_W-1:0] out,
   input  logic              clk,
   input  logic              rst
);

   logic [OP_W-1:0] r_a;
   logic [OP_W-1:0] r_b;
   row_t            r_s2 [0:5];
   row_t            r_s3 [0:1];

   row_t w_pp [0:15];
   row_t w_l1 [0:10];
   row_t w_l2 [0:7];
   row_t w_l3 [0:5];
   row_t w_l4 [0:3];
   row_t w_l5 [0:2];
   row_t w_l6 [0:1];

   genvar gi;

   // Partial-product rows, each already shifted to weight 2^gi.
   generate
      for (gi = 0; gi < OP_W; gi++) begin : g_pp
         assign w_pp[gi] = {16'b0, r_a & {OP_W{r_b[gi]}}} << gi;
      end

      for (gi = 0; gi < 5; gi++) begin : g_l1
         wallace_csa u_csa (
            .i_x(w_pp[3*gi]), .i_y(w_pp[3*gi+1]), .i_z(w_pp[3*gi+2]),
            .o_sum(w_l1[2*gi]), .o_carry(w_l1[2*gi+1])
         );
      end

      for (gi = 0; gi < 3; gi++) begin : g_l2
         wallace_csa u_csa (
            .i_x(w_l1[3*gi]), .i_y(w_l1[3*gi+1]), .i_z(w_l1[3*gi+2]),
            .o_sum(w_l2[2*gi]), .o_carry(w_l2[2*gi+1])
         );
      end

      for (gi = 0; gi < 2; gi++) begin : g_l3
         wallace_csa u_csa (
            .i_x(w_l2[3*gi]), .i_y(w_l2[3*gi+1]), .i_z(w_l2[3*gi+2]),
            .o_sum(w_l3[2*gi]), .o_carry(w_l3[2*gi+1])
         );
      end

      for (gi = 0; gi < 2; gi++) begin : g_l4
         wallace_csa u_csa (
            .i_x(r_s2[3*gi]), .i_y(r_s2[3*gi+1]), .i_z(r_s2[3*gi+2]),
            .o_sum(w_l4[2*gi]), .o_carry(w_l4[2*gi+1])
         );
      end
   endgenerate

   // Rows left over at each level bypass straight to the next one.
   assign w_l1[10] = w_pp[15];
   assign w_l2[6]  = w_l1[9];
   assign w_l2[7]  = w_l1[10];
   assign w_l3[4]  = w_l2[6];
   assign w_l3[5]  = w_l2[7];
   assign w_l5[2]  = w_l4[3];

   wallace_csa u_csa_l5 (
      .i_x(w_l4[0]), .i_y(w_l4[1]), .i_z(w_l4[2]),
      .o_sum(w_l5[0]), .o_carry(w_l5[1])
   );

   wallace_csa u_csa_l6 (
      .i_x(w_l5[0]), .i_y(w_l5[1]), .i_z(w_l5[2]),
      .o_sum(w_l6[0]), .o_carry(w_l6[1])
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a <= '0;
         r_b <= '0;
         for (int k = 0; k < 6; k++) r_s2[k] <= '0;
         for (int k = 0; k < 2; k++) r_s3[k] <= '0;
         out <= '0;
      end else begin
         r_a <= a;
         r_b <= b;
         for (int k = 0; k < 6; k++) r_s2[k] <= w_l3[k];
         for (int k = 0; k < 2; k++) r_s3[k] <= w_l6[k];
         out <= r_s3[0] + r_s3[1];
      end
   end

endmodule

// File: tb/tb_wallace_pipe.sv
// Self-checking bench for wallace_pipe against a latency-queue reference model.
module tb_wallace_pipe;

   logic        clk;
   logic        rst;
   logic [15:0] a;
   logic [15:0] b;
   logic [31:0] out;

   int checks = 0;
   int errors = 0;
   int txn    = 0;

   // Products still in flight, oldest first; a reset refills it with zeros.
   logic [31:0] exp_q [$];

   wallace_pipe dut (
      .a   (a),
      .b   (b),
      .out (out),
      .clk (clk),
      .rst (rst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs, advance the model, return what out must show.
   task automatic tick(input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic trst, output logic [31:0] texp);
      logic [31:0] prod;
      a   = ta;
      b   = tb_v;
      rst = trst;
      prod = 32'(ta) * 32'(tb_v);
      @(posedge clk);
      if (trst) begin
         texp  = 32'd0;
         exp_q = '{32'd0, 32'd0, 32'd0};
      end else begin
         texp = exp_q.pop_front();
         exp_q.push_back(prod);
      end
      #1;
      txn++;
   endtask

   task automatic test_reset();
      logic [31:0] e;
      for (int i = 0; i < 2; i++) begin
         tick(16'hFFFF, 16'hFFFF, 1'b1, e);
         checks++;
         if (out !== 32'd0) begin
            errors++;
            $display("FAIL reset_hold cyc %0d out=%h exp=%h", i, out, 32'd0);
         end
         $display("txn %0d reset_hold out=%h", txn, out);
      end
      for (int i = 1; i <= 4; i++) begin
         tick(16'hFFFF, 16'hFFFF, 1'b0, e);
         checks++;
         if (out !== e) begin
            errors++;
            $display("FAIL reset_release R+%0d out=%h exp=%h", i, out, e);
         end
         $display("txn %0d reset_release R+%0d out=%h exp=%h", txn, i, out, e);
      end
   endtask

   task automatic test_max();
      logic [31:0] e;
      for (int i = 0; i < 6; i++) begin
         tick(16'hFFFF, 16'hFFFF, 1'b0, e);
         checks++;
         if (out !== e || out !== 32'hFFFE0001) begin
            errors++;
            $display("FAIL max_hold cyc %0d out=%h exp=%h", i, out, 32'hFFFE0001);
         end
         $display("txn %0d max_hold out=%h", txn, out);
      end
   endtask

   task automatic test_corners();
      logic [15:0] ca [0:4] = '{16'h0000, 16'h0001, 16'h8000, 16'hFFFF, 16'h8000};
      logic [15:0] cb [0:4] = '{16'h1234, 16'hABCD, 16'h0002, 16'h0001, 16'h8000};
      logic [31:0] e;
      for (int i = 0; i < 9; i++) begin
         if (i < 5) tick(ca[i], cb[i], 1'b0, e);
         else       tick(16'h0000, 16'h0000, 1'b0, e);
         checks++;
         if (out !== e) begin
            errors++;
            $display("FAIL corner cyc %0d out=%h exp=%h", i, out, e);
         end
         $display("txn %0d corner cyc %0d out=%h exp=%h", txn, i, out, e);
      end
   endtask

   task automatic test_stream();
      logic [31:0] e;
      logic [15:0] ra, rb;
      for (int i = 0; i < 1004; i++) begin
         ra = (i < 1000) ? 16'($urandom) : 16'h0;
         rb = (i < 1000) ? 16'($urandom) : 16'h0;
         tick(ra, rb, 1'b0, e);
         checks++;
         if (out !== e) begin
            errors++;
            $display("FAIL stream idx %0d out=%h exp=%h", i, out, e);
         end
         $display("txn %0d stream a=%h b=%h out=%h exp=%h", txn, ra, rb, out, e);
      end
   endtask

   task automatic test_mid_reset();
      logic [31:0] e;
      logic [15:0] ra, rb;
      for (int i = 0; i < 10; i++) begin
         ra = 16'($urandom_range(1, 65535));
         rb = 16'($urandom_range(1, 65535));
         tick(ra, rb, (i == 4), e);
         checks++;
         if (out !== e) begin
            errors++;
            $display("FAIL mid_reset cyc %0d out=%h exp=%h", i, out, e);
         end
         $display("txn %0d mid_reset rst=%0d out=%h exp=%h", txn, (i == 4), out, e);
      end
   endtask

   task automatic test_sweep();
      logic [31:0] e;
      for (int k = 0; k < 260; k++) begin
         if (k < 256) tick(16'(1 << (k / 16)), 16'(1 << (k % 16)), 1'b0, e);
         else         tick(16'h0, 16'h0, 1'b0, e);
         checks++;
         if (out !== e) begin
            errors++;
            $display("FAIL sweep idx %0d out=%h exp=%h", k, out, e);
         end
         $display("txn %0d sweep out=%h exp=%h", txn, out, e);
      end
   endtask

   initial begin
      a     = 16'h0;
      b     = 16'h0;
      rst   = 1'b1;
      exp_q = '{32'd0, 32'd0, 32'd0};
      test_reset();
      test_max();
      test_corners();
      test_stream();
      test_mid_reset();
      test_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
